// File: rtl/bsg_counter_window_sampler_pkg.sv
// bsg_counter_window_pkg
//   Shared types and default widths for the windowed event-counter sampler.
//   - state_e          : controller state (IDLE / COUNT)
//   - *_default_c      : default parameter values used by the sampler,
//                        its output interface and the saturating counter.
package bsg_counter_window_pkg;

  localparam int width_default_c      = 24;
  localparam int len_width_default_c  = 16;
  localparam int drop_width_default_c = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage : bsg_counter_window_pkg

// File: rtl/bsg_counter_window_sampler_if.sv
// bsg_counter_window_sampler_if
//   One-deep valid/ready channel carrying a window snapshot.
//   - sample_o       : snapshot count
//   - sample_sat_o   : snapshot saturated
//   - sample_v_o     : snapshot valid
//   - sample_ready_i : consumer accepts when sample_v_o & sample_ready_i
//   Modports: master (sampler side, drives the snapshot) and
//             slave  (collector side, drives ready).
interface bsg_counter_window_sampler_if
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p = width_default_c
) ();

  logic [width_p-1:0] sample_o;
  logic               sample_sat_o;
  logic               sample_v_o;
  logic               sample_ready_i;

  modport master (
    output sample_o,
    output sample_sat_o,
    output sample_v_o,
    input  sample_ready_i
  );

  modport slave (
    input  sample_o,
    input  sample_sat_o,
    input  sample_v_o,
    output sample_ready_i
  );

endinterface : bsg_counter_window_sampler_if

// File: rtl/bsg_counter_sat_clear_up.sv
// bsg_counter_sat_clear_up
//   Saturating up-counter with synchronous clear.
//   - clk_i, reset_n_i : clock, asynchronous active-low reset
//   - clear_i          : next value is zero (wins over up_i), sat cleared
//   - up_i             : increment by one; at all-ones the count holds
//                        and sat_o becomes sticky-set
//   - count_o          : current count
//   - sat_o            : an increment was lost since the last clear
module bsg_counter_sat_clear_up
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p = width_default_c
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o,
  output logic               sat_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               sat_q, sat_d;
  logic               at_max;

  assign at_max = &count_q;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear_i) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (up_i) begin
      if (at_max) sat_d   = 1'b1;
      else        count_d = count_q + width_p'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops
  // sample their inputs from the same edge regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule : bsg_counter_sat_clear_up

// File: rtl/bsg_counter_window_sampler.sv
// bsg_counter_window_sampler
//   Counts event_i pulses over back-to-back windows of window_len_i cycles
//   and presents each window total on a one-deep valid/ready buffer.
//   Ports:
//   - clk_i, reset_n_i : clock, asynchronous active-low reset
//   - en_i             : level enable; low aborts the current window
//   - window_len_i     : window length, captured when leaving IDLE
//   - event_i          : event strobe, one count per high cycle
//   - sample_if        : snapshot channel (master side)
//   - busy_o           : a window is in progress
//   - dropped_o        : saturating count of snapshots lost because the
//                        buffer was still full at window end
module bsg_counter_window_sampler
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p      = width_default_c,
  parameter int len_width_p  = len_width_default_c,
  parameter int drop_width_p = drop_width_default_c
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [len_width_p-1:0]  window_len_i,
  input  logic                    event_i,
  bsg_counter_window_sampler_if.master sample_if,
  output logic                    busy_o,
  output logic [drop_width_p-1:0] dropped_o
);

  state_e                  state_q, state_d;
  logic [len_width_p-1:0]  len_q, len_d;
  logic [len_width_p-1:0]  timer_q, timer_d;
  logic [width_p-1:0]      sample_q, sample_d;
  logic                    sample_sat_q, sample_sat_d;
  logic                    sample_v_q, sample_v_d;
  logic [drop_width_p-1:0] dropped_q, dropped_d;

  logic [width_p-1:0]      count;
  logic                    count_sat;
  logic                    counting;
  logic                    window_end;
  logic                    overflow;
  logic [width_p-1:0]      final_count;
  logic                    final_sat;
  logic                    load;
  logic                    cnt_clear;
  logic                    cnt_up;

  // A cycle only contributes to a window while enabled in COUNT; a low
  // en_i in COUNT discards the window, including on its last cycle.
  assign counting   = (state_q == COUNT) && en_i;
  assign window_end = counting && (timer_q == (len_q - len_width_p'(1)));

  // The counter is held cleared outside live windows, so arming always
  // starts from zero, and it is cleared on the window-end edge so the
  // following window starts with no idle gap.
  assign cnt_clear = !counting || window_end;
  assign cnt_up    = counting && event_i;

  bsg_counter_sat_clear_up #(
    .width_p (width_p)
  ) u_event_count (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clear),
    .up_i      (cnt_up),
    .count_o   (count),
    .sat_o     (count_sat)
  );

  // The registered count lags one event behind: fold in the last cycle's
  // event here so the snapshot covers all len cycles of the window.
  assign overflow    = event_i && (&count);
  assign final_count = (event_i && !(&count)) ? count + width_p'(1) : count;
  assign final_sat   = count_sat || overflow;

  // The buffer can take a new snapshot if empty or drained this same edge.
  assign load = window_end && (!sample_v_q || sample_if.sample_ready_i);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (en_i && (window_len_i != '0)) begin
          state_d = COUNT;
          len_d   = window_len_i;
        end
      end
      COUNT: begin
        if (!en_i) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (window_end) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + len_width_p'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    sample_d     = sample_q;
    sample_sat_d = sample_sat_q;
    sample_v_d   = sample_v_q && !sample_if.sample_ready_i;
    dropped_d    = dropped_q;
    if (load) begin
      sample_d     = final_count;
      sample_sat_d = final_sat;
      sample_v_d   = 1'b1;
    end else if (window_end && !(&dropped_q)) begin
      dropped_d = dropped_q + drop_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      timer_q      <= '0;
      sample_q     <= '0;
      sample_sat_q <= 1'b0;
      sample_v_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      timer_q      <= timer_d;
      sample_q     <= sample_d;
      sample_sat_q <= sample_sat_d;
      sample_v_q   <= sample_v_d;
      dropped_q    <= dropped_d;
    end
  end

  assign sample_if.sample_o     = sample_q;
  assign sample_if.sample_sat_o = sample_sat_q;
  assign sample_if.sample_v_o   = sample_v_q;
  assign busy_o                 = (state_q == COUNT);
  assign dropped_o              = dropped_q;

endmodule : bsg_counter_window_sampler

// File: tb/tb_bsg_counter_window_sampler.sv
// tb_bsg_counter_window_sampler
//   Self-checking bench for bsg_counter_window_sampler with a narrow
//   configuration (4-bit count, 8-bit length, 3-bit drop counter) so that
//   count and drop saturation are reached quickly.
module tb_bsg_counter_window_sampler;

  localparam int W    = 4;
  localparam int LW   = 8;
  localparam int DW   = 3;
  localparam int MAX  = (1 << W) - 1;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [LW-1:0] wl = '0;
  logic          ev = 1'b0;
  logic          busy;
  logic [DW-1:0] dropped;

  int n_cmp  = 0;
  int n_fail = 0;

  bsg_counter_window_sampler_if #(.width_p(W)) smp_if ();

  bsg_counter_window_sampler #(
    .width_p      (W),
    .len_width_p  (LW),
    .drop_width_p (DW)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .en_i         (en),
    .window_len_i (wl),
    .event_i      (ev),
    .sample_if    (smp_if),
    .busy_o       (busy),
    .dropped_o    (dropped)
  );

  always #5 clk = ~clk;

  // Packed view {valid, sample, sat, busy, dropped}.
  logic [W+DW+2:0] dut_vec;
  assign dut_vec = {smp_if.sample_v_o, smp_if.sample_o, smp_if.sample_sat_o, busy, dropped};

  // Reference model: a window is a list of cycles whose events are summed
  // with an unbounded integer; the snapshot is that sum clipped to MAX.
  logic m_active;
  int   m_len, m_pos, m_events;
  logic m_v, m_sat;
  int   m_val, m_drop;

  function automatic logic [W+DW+2:0] model_vec();
    return {m_v, W'(m_val), m_sat, m_active, DW'(m_drop)};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_len = 0; m_pos = 0; m_events = 0;
    m_v = 1'b0; m_sat = 1'b0; m_val = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic rdy;
    logic acc;
    rdy = smp_if.sample_ready_i;
    acc = m_v && rdy;
    if (!m_active) begin
      if (acc) m_v = 1'b0;
      if (en && wl != 0) begin
        m_active = 1'b1; m_len = int'(wl); m_pos = 0; m_events = 0;
      end
    end else if (!en) begin
      if (acc) m_v = 1'b0;
      m_active = 1'b0; m_pos = 0; m_events = 0;
    end else begin
      m_events += int'(ev);
      m_pos++;
      if (m_pos == m_len) begin
        if (!m_v || rdy) begin
          m_v   = 1'b1;
          m_val = (m_events > MAX) ? MAX : m_events;
          m_sat = (m_events > MAX);
        end else if (m_drop < DMAX) begin
          m_drop++;
        end
        m_pos = 0; m_events = 0;
      end else if (acc) begin
        m_v = 1'b0;
      end
    end
  endtask

  // Advance one clock: the model consumes the inputs present at the edge,
  // outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0; wl = '0; ev = 1'b0;
    smp_if.sample_ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    if (smp_if.sample_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", smp_if.sample_v_o); end
    n_cmp++;
    if (smp_if.sample_o !== '0) begin n_fail++; $display("FAIL reset_sample got %h exp 0", smp_if.sample_o); end
    n_cmp++;
    if (smp_if.sample_sat_o !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", smp_if.sample_sat_o); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++;
    if (dropped !== '0) begin n_fail++; $display("FAIL reset_dropped got %h exp 0", dropped); end
    n_cmp++;
    do_reset();
    // Events and zero length in IDLE must not start anything.
    ev = 1'b1; en = 1'b1; wl = '0;
    repeat (3) tick();
    if (dut_vec !== model_vec() || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_len0 got %h exp %h", dut_vec, model_vec());
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    logic ev_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    en = 1'b1; wl = LW'(4); ev = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      ev = ev_pat[i];
      tick();
      if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL basic_model cyc%0d got %h exp %h", i, dut_vec, model_vec()); end
      n_cmp++;
    end
    if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(3) || smp_if.sample_sat_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_sample got v=%b s=%0d sat=%b exp v=1 s=3 sat=0",
                         smp_if.sample_v_o, smp_if.sample_o, smp_if.sample_sat_o);
    end
    n_cmp++;
    ev = 1'b0;
    tick();
    if (smp_if.sample_v_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_next got v=%b busy=%b exp v=0 busy=1", smp_if.sample_v_o, busy);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int n_samples;
    int n_bad;
    do_reset();
    en = 1'b1; wl = LW'(2); ev = 1'b0;
    tick();
    ev = 1'b1;
    n_samples = 0; n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL b2b_model cyc%0d got %h exp %h", i, dut_vec, model_vec()); end
      n_cmp++;
      if (smp_if.sample_v_o === 1'b1) begin
        n_samples++;
        if (smp_if.sample_o !== W'(2)) n_bad++;
      end
    end
    if (n_samples != 5 || n_bad != 0) begin
      n_fail++; $display("FAIL b2b_count got %0d samples (%0d wrong) exp 5 samples of 2", n_samples, n_bad);
    end
    n_cmp++;
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; wl = LW'(20); ev = 1'b0;
    tick();
    ev = 1'b1;
    repeat (20) tick();
    if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(MAX) || smp_if.sample_sat_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_sample got v=%b s=%0d sat=%b exp v=1 s=%0d sat=1",
                         smp_if.sample_v_o, smp_if.sample_o, smp_if.sample_sat_o, MAX);
    end
    n_cmp++;
    for (int i = 0; i < 20; i++) begin
      ev = (i % 4 == 0);
      tick();
    end
    if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(5) || smp_if.sample_sat_o !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear got v=%b s=%0d sat=%b exp v=1 s=5 sat=0",
                         smp_if.sample_v_o, smp_if.sample_o, smp_if.sample_sat_o);
    end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    logic evs [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    smp_if.sample_ready_i = 1'b0;
    en = 1'b1; wl = LW'(3); ev = 1'b0;
    tick();
    ev = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL bp_model cyc%0d got %h exp %h", i, dut_vec, model_vec()); end
      n_cmp++;
    end
    if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(3) || dropped !== DW'(2)) begin
      n_fail++; $display("FAIL bp_hold got v=%b s=%0d drop=%0d exp v=1 s=3 drop=2",
                         smp_if.sample_v_o, smp_if.sample_o, dropped);
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      ev = evs[i];
      smp_if.sample_ready_i = (i == 2);
      tick();
    end
    if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(1) || dropped !== DW'(2)) begin
      n_fail++; $display("FAIL bp_swap got v=%b s=%0d drop=%0d exp v=1 s=1 drop=2",
                         smp_if.sample_v_o, smp_if.sample_o, dropped);
    end
    n_cmp++;
    tick();
    if (smp_if.sample_v_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b exp 0", smp_if.sample_v_o); end
    n_cmp++;
  endtask

  task automatic test_disable();
    logic e;
    do_reset();
    en = 1'b1; wl = LW'(8); ev = 1'b1;
    tick();
    repeat (4) tick();
    en = 1'b0;
    tick();
    if (busy !== 1'b0 || smp_if.sample_v_o !== 1'b0) begin
      n_fail++; $display("FAIL dis_abort got busy=%b v=%b exp busy=0 v=0", busy, smp_if.sample_v_o);
    end
    n_cmp++;
    en = 1'b1; wl = '0;
    repeat (3) tick();
    if (busy !== 1'b0 || smp_if.sample_v_o !== 1'b0) begin
      n_fail++; $display("FAIL dis_len0 got busy=%b v=%b exp busy=0 v=0", busy, smp_if.sample_v_o);
    end
    n_cmp++;
    wl = LW'(1); ev = 1'b0;
    tick();
    wl = LW'(6);  // ignored until re-armed through IDLE
    for (int i = 0; i < 8; i++) begin
      e = 1'($urandom_range(0, 1));
      ev = e;
      tick();
      if (smp_if.sample_v_o !== 1'b1 || smp_if.sample_o !== W'(e) || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL len1 cyc%0d got v=%b s=%0d exp v=1 s=%0d", i, smp_if.sample_v_o, smp_if.sample_o, e);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      wl = LW'($urandom_range(0, 5));
      ev = 1'($urandom_range(0, 1));
      smp_if.sample_ready_i = (i < 800) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      tick();
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL rand cyc%0d got %h exp %h", i, dut_vec, model_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    smp_if.sample_ready_i = 1'b0;
    en = 1'b1; wl = LW'(3); ev = 1'b1;
    tick();
    repeat (4) tick();
    if (smp_if.sample_v_o !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ar_setup got v=%b busy=%b exp v=1 busy=1", smp_if.sample_v_o, busy);
    end
    n_cmp++;
    #1 reset_n = 1'b0;
    #1;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL ar_immediate got %h exp 0", dut_vec); end
    n_cmp++;
    model_reset();
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL ar_after got %h exp %h", dut_vec, model_vec()); end
    n_cmp++;
  endtask

  initial begin
    smp_if.sample_ready_i = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_disable();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_bsg_counter_window_sampler
